// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-write scoreboard for in-order issue
// Counts outstanding writes per register and stalls decode on source or counter-overflow hazards.
module regfile_scoreboard #(
  parameter int         NREG  = 15,
  parameter int         CNT_W = 2,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [3:0]      srcA,
  input  logic [3:0]      srcB,
  input  logic [3:0]      dstE,
  input  logic [3:0]      dstM,
  input  logic            wb_valid,
  input  logic [3:0]      wb_dstE,
  input  logic [3:0]      wb_dstM,
  input  logic            cx_valid,
  input  logic [3:0]      cx_dstE,
  input  logic [3:0]      cx_dstM,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] busy_mask,
  output logic            err_underflow
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [SW-1:0]    inc_r [NREG];
  logic [SW-1:0]    dec_r [NREG];
  logic [SW-1:0]    tot_r [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;
  logic             haz_a, haz_b, haz_o;

  // Ids at or above NREG never equal a tracked index, so they fall out as "no register".
  function automatic logic hit(input logic [3:0] id, input int r);
    return (id != RNONE) && (id == 4'(r));
  endfunction

  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    haz_o = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      inc_r[r] = SW'(hit(dstE, r)) + SW'(hit(dstM, r));
      dec_r[r] = SW'(wb_valid & hit(wb_dstE, r)) + SW'(wb_valid & hit(wb_dstM, r))
               + SW'(cx_valid & hit(cx_dstE, r)) + SW'(cx_valid & hit(cx_dstM, r));
      haz_a = haz_a | (hit(srcA, r) & (cnt_q[r] != '0));
      haz_b = haz_b | (hit(srcB, r) & (cnt_q[r] != '0));
      haz_o = haz_o | ((SW'(cnt_q[r]) + inc_r[r]) > CNT_MAX);
    end
    stall      = issue_valid & (haz_a | haz_b | haz_o);
    issue_fire = issue_valid & ~stall;
  end

  // A fired issue never overflows, so a non-negative result always fits CNT_W bits.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      tot_r[r] = SW'(cnt_q[r]) + (issue_fire ? inc_r[r] : '0);
      if (tot_r[r] < dec_r[r]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(tot_r[r] - dec_r[r]);
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_mask     = busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
// Directed scenarios followed by randomized traffic against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int NREG = 15;
  localparam logic [3:0] RN = 4'hF;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid, wb_valid, cx_valid;
  logic [3:0]      srcA, srcB, dstE, dstM, wb_dstE, wb_dstM, cx_dstE, cx_dstM;
  logic            stall, issue_fire, err_underflow;
  logic [NREG-1:0] busy_mask;

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt [NREG];
  bit m_err;

  logic            obs_stall, obs_fire, obs_err;
  logic [NREG-1:0] obs_busy;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .wb_valid(wb_valid), .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
    .cx_valid(cx_valid), .cx_dstE(cx_dstE), .cx_dstM(cx_dstM),
    .stall(stall), .issue_fire(issue_fire),
    .busy_mask(busy_mask), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit tracked(input logic [3:0] id);
    return (id != RN) && (int'(id) < NREG);
  endfunction

  task automatic drive(input bit rst, input bit iv, input logic [3:0] sa, input logic [3:0] sb,
                       input logic [3:0] de, input logic [3:0] dm,
                       input bit wv, input logic [3:0] we, input logic [3:0] wm,
                       input bit cv, input logic [3:0] ce, input logic [3:0] cm);
    reset = rst; issue_valid = iv; srcA = sa; srcB = sb; dstE = de; dstM = dm;
    wb_valid = wv; wb_dstE = we; wb_dstM = wm; cx_valid = cv; cx_dstE = ce; cx_dstM = cm;
  endtask

  task automatic idle();
    drive(0, 0, RN, RN, RN, RN, 0, RN, RN, 0, RN, RN);
  endtask

  // One clock: compare combinational outputs mid-cycle, then registered state after the edge.
  task automatic cycle();
    int  inc [NREG];
    int  dec [NREG];
    bit  hz, fire;
    logic [NREG-1:0] exp_busy;
    foreach (inc[r]) begin inc[r] = 0; dec[r] = 0; end
    if (tracked(dstE)) inc[dstE]++;
    if (tracked(dstM)) inc[dstM]++;
    if (wb_valid && tracked(wb_dstE)) dec[wb_dstE]++;
    if (wb_valid && tracked(wb_dstM)) dec[wb_dstM]++;
    if (cx_valid && tracked(cx_dstE)) dec[cx_dstE]++;
    if (cx_valid && tracked(cx_dstM)) dec[cx_dstM]++;
    hz = 0;
    if (tracked(srcA) && m_cnt[srcA] > 0) hz = 1;
    if (tracked(srcB) && m_cnt[srcB] > 0) hz = 1;
    foreach (m_cnt[r]) if (m_cnt[r] + inc[r] > 3) hz = 1;
    fire = issue_valid && !hz;
    @(negedge clk);
    obs_stall = stall;
    obs_fire  = issue_fire;
    check("stall", stall, issue_valid && hz);
    check("issue_fire", issue_fire, fire);
    @(posedge clk);
    if (reset) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 0;
    end else begin
      foreach (m_cnt[r]) begin
        int t;
        t = m_cnt[r] + (fire ? inc[r] : 0);
        if (t < dec[r]) begin m_cnt[r] = 0; m_err = 1; end
        else m_cnt[r] = t - dec[r];
      end
    end
    #1;
    foreach (m_cnt[r]) exp_busy[r] = (m_cnt[r] != 0);
    obs_busy = busy_mask;
    obs_err  = err_underflow;
    check("busy_mask", busy_mask, exp_busy);
    check("err_underflow", err_underflow, m_err);
  endtask

  task automatic do_reset();
    drive(1, 0, RN, RN, RN, RN, 0, RN, RN, 0, RN, RN);
    cycle();
    idle();
  endtask

  function automatic logic [3:0] rid();
    return ($urandom_range(0, 3) == 0) ? RN : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_err = 0;
    #1;
    do_reset();
    check("reset_busy", obs_busy, 0);
    check("reset_err", obs_err, 0);

    drive(0, 1, RN, RN, 4'd3, RN, 0, RN, RN, 0, RN, RN); cycle();
    check("r34_fire", obs_fire, 1);
    check("r34_busy", obs_busy, 15'h0008);
    drive(0, 1, 4'd3, RN, RN, RN, 1, 4'd3, RN, 0, RN, RN); cycle();
    check("r35_stall_n", obs_stall, 1);
    check("r35_bit3_clear", obs_busy[3], 0);
    drive(0, 1, 4'd3, RN, RN, RN, 0, RN, RN, 0, RN, RN); cycle();
    check("r35_fire_n1", obs_fire, 1);

    drive(0, 1, RN, RN, 4'd4, 4'd4, 0, RN, RN, 0, RN, RN); cycle();
    check("r36_bit4_set", obs_busy[4], 1);
    drive(0, 0, RN, RN, RN, RN, 1, 4'd4, RN, 0, RN, RN); cycle();
    check("r36_bit4_after1", obs_busy[4], 1);
    cycle();
    check("r36_bit4_after2", obs_busy[4], 0);

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, RN, RN, 4'd5, RN, 0, RN, RN, 0, RN, RN); cycle();
    end
    cycle();
    check("r37_overflow_stall", obs_stall, 1);
    drive(0, 0, RN, RN, RN, RN, 1, 4'd5, RN, 0, RN, RN); cycle();
    drive(0, 1, RN, RN, 4'd5, RN, 1, 4'd5, RN, 0, RN, RN); cycle();
    check("r37_fire_with_wb", obs_fire, 1);
    drive(0, 1, RN, RN, 4'd5, RN, 0, RN, RN, 0, RN, RN); cycle();
    check("r37_cnt2_fire", obs_fire, 1);
    cycle();
    check("r37_cnt3_stall", obs_stall, 1);

    do_reset();
    drive(0, 1, RN, RN, 4'd6, RN, 0, RN, RN, 0, RN, RN); cycle();
    drive(0, 0, RN, RN, RN, RN, 1, 4'd6, RN, 1, 4'd6, RN); cycle();
    check("r38_err", obs_err, 1);
    check("r38_bit6", obs_busy[6], 0);
    idle();
    for (int i = 0; i < 3; i++) cycle();
    check("r38_err_sticky", obs_err, 1);

    drive(0, 1, RN, RN, 4'd0, 4'd1, 0, RN, RN, 0, RN, RN); cycle();
    drive(1, 1, 4'd0, 4'd0, RN, RN, 1, 4'd0, RN, 0, RN, RN); cycle();
    check("r39_busy", obs_busy, 0);
    check("r39_err", obs_err, 0);
    drive(0, 1, 4'd0, 4'd0, RN, RN, 0, RN, RN, 0, RN, RN); cycle();
    check("r39_stall", obs_stall, 0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), rid(), rid(), rid(), rid(),
            ($urandom_range(0, 2) == 0), rid(), rid(), ($urandom_range(0, 7) == 0), rid(), rid());
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter NREG, default 15, number of tracked registers, ids 0..NREG-1 (%rax..%r14).
REQ-002 Parameter CNT_W, default 2, width of each per-register pending counter; maximum count is 2^CNT_W-1 (3).
REQ-003 Parameter RNONE, default 4'hF, register id meaning "no register"; it is never tracked and never causes a stall.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high; clears all state.
REQ-007 issue_valid  in  1  decode stage presents an instruction for issue.
REQ-008 srcA, srcB  in  4 each  source register ids read by the presented instruction.
REQ-009 dstE, dstM  in  4 each  destination register ids written by the presented instruction.
REQ-010 wb_valid  in  1  writeback retires one instruction this cycle.
REQ-011 wb_dstE, wb_dstM  in  4 each  destination ids of the retiring instruction.
REQ-012 cx_valid  in  1  one in-flight instruction is cancelled (squashed) this cycle.
REQ-013 cx_dstE, cx_dstM  in  4 each  destination ids of the cancelled instruction.
REQ-014 stall  out  1  combinational; decode must hold the presented instruction.
REQ-015 issue_fire  out  1  combinational; issue_valid & ~stall.
REQ-016 busy_mask  out  NREG  registered; bit r = (cnt[r] != 0).
REQ-017 err_underflow  out  1  registered, sticky until reset.

Function
REQ-018 Keep one CNT_W-bit counter cnt[r] per tracked register, holding the number of issued, not-yet-retired or cancelled writes to r.
REQ-019 Source hazard: hazA = (srcA != RNONE) & (cnt[srcA] != 0); hazB is defined the same way for srcB.
REQ-020 Increment demand inc[r] = (dstE==r) + (dstM==r), excluding RNONE; dstE==dstM==r gives inc 2 (popq %rsp).
REQ-021 Overflow hazard: hazO = 1 when any r has cnt[r] + inc[r] > 2^CNT_W-1.
REQ-022 stall = issue_valid & (hazA | hazB | hazO); stall is 0 whenever issue_valid is 0.
REQ-023 stall and hazards are computed from current registered counters only; retire or cancel in the same cycle does not clear a stall until the next cycle.
REQ-024 Decrement demand dec[r] = wb_valid*((wb_dstE==r)+(wb_dstM==r)) + cx_valid*((cx_dstE==r)+(cx_dstM==r)); RNONE is excluded and the range is 0..4.
REQ-025 Next state: cnt[r] <= cnt[r] + (issue_fire ? inc[r] : 0) - dec[r], computed at CNT_W+2 bits and then clamped to 0 at the low end.
REQ-026 Underflow: when cnt[r] + issued increment < dec[r] for any r, cnt[r] <= 0 and err_underflow <= 1.
REQ-027 Issue, retire and cancel targeting the same register in one cycle are all applied; the net change is inc - dec.
REQ-028 Ids in NREG..14 that are not RNONE are treated as RNONE; they are ignored and raise no error.
REQ-029 busy_mask reflects the post-update counters one cycle after the causing event.
REQ-030 Latency: a write issued in cycle N blocks a dependent source from cycle N+1 until the cycle after its last retire or cancel.

Reset
REQ-031 While reset=1 at a rising edge: all cnt[r] <= 0, busy_mask <= 0, err_underflow <= 0.
REQ-032 During reset, issue, wb and cx inputs are ignored; stall follows REQ-022 from the cleared counters, so it is 0 after the first reset edge.
REQ-033 Reset asserted mid-operation discards all pending counts; there is no drain.

Verification
REQ-034 Reset then issue dstE=3, srcs RNONE -> issue_fire=1; next cycle busy_mask=15'h0008. Next, srcA=3 -> stall=1, issue_fire=0.
REQ-035 With cnt[3]=1: wb_valid with wb_dstE=3 in cycle N while srcA=3 is presented -> stall=1 in N; stall=0 and issue_fire=1 in N+1; busy_mask bit3 clear in N+1.
REQ-036 Issue dstE=4, dstM=4 (popq %rsp) -> cnt[4]=2. One retire with wb_dstE=4, wb_dstM=RNONE -> cnt[4]=1, bit4 still set. A second such retire -> bit4 clear.
REQ-037 With cnt[5]=3: issue dstE=5 -> stall=1 (overflow). Simultaneous issue dstE=5 plus retire wb_dstE=5 at cnt[5]=2 -> cnt stays 2.
REQ-038 With cnt[6]=1: wb_dstE=6 and cx_dstE=6 in the same cycle -> cnt[6]=0 and err_underflow=1, held until reset.
REQ-039 With several counters nonzero, assert reset for one cycle -> busy_mask=0, err_underflow=0, stall=0 for srcA=srcB=0.
